// File: rtl/axi_read_arbiter.sv
// Two-requester (instruction fetch / data cache) arbiter for the shared AXI read path.
// Issues one 8-beat 64-byte INCR line fill at a time and steers the R beats back to its owner.
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_req_ready,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_resp_data,
    output logic                  i_resp_last,
    output logic                  i_resp_err,

    input  logic                  d_req_valid,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    output logic                  d_req_ready,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_resp_data,
    output logic                  d_resp_last,
    output logic                  d_resp_err,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(63);

    state_t                  state;
    logic                    owner;
    logic                    last_grant;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              beat_cnt;
    logic                    arvalid_q;
    logic                    rready_q;

    logic                    grant_i;
    logic                    grant_d;
    logic                    grant_any;
    logic [ADDR_WIDTH-1:0]   grant_addr;
    logic                    beat_fire;

    // Round robin only matters on a tie: the side that did not win last time goes first.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE && !reset) begin
            if (i_req_valid && d_req_valid) begin
                grant_i = last_grant;
                grant_d = !last_grant;
            end else begin
                grant_i = i_req_valid;
                grant_d = d_req_valid;
            end
        end
    end

    assign grant_any  = grant_i | grant_d;
    assign grant_addr = grant_d ? d_req_addr : i_req_addr;
    assign beat_fire  = rready_q && m_axi_rvalid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            beat_cnt   <= 3'd0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_d;
                        last_grant <= grant_d;
                        addr_q     <= grant_addr & LINE_MASK;
                        arvalid_q  <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        beat_cnt  <= 3'd0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_rvalid) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (m_axi_rlast) begin
                            rready_q <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign i_req_ready   = grant_i;
    assign d_req_ready   = grant_d;

    assign m_axi_arid    = ID_WIDTH'(owner);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd7;
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

    // Requesters never stall, so beats pass straight through; only the owner sees valid.
    assign i_resp_valid  = beat_fire && !owner;
    assign i_resp_data   = m_axi_rdata;
    assign i_resp_last   = i_resp_valid && m_axi_rlast;
    assign i_resp_err    = i_resp_valid && (|m_axi_rresp);

    assign d_resp_valid  = beat_fire && owner;
    assign d_resp_data   = m_axi_rdata;
    assign d_resp_last   = d_resp_valid && m_axi_rlast;
    assign d_resp_err    = d_resp_valid && (|m_axi_rresp);

    // Burst framing: rlast must land exactly on the eighth beat, with the issued id.
    a_rlast_early: assert property (@(posedge clk) disable iff (reset)
        (beat_fire && m_axi_rlast) |-> (beat_cnt == 3'd7));
    a_rlast_missing: assert property (@(posedge clk) disable iff (reset)
        (beat_fire && beat_cnt == 3'd7) |-> m_axi_rlast);
    a_rid_match: assert property (@(posedge clk) disable iff (reset)
        beat_fire |-> (m_axi_rid == m_axi_arid));

endmodule
